// File: rtl/nonce_result_collector.sv
// Collects per-lane hash results, counts nonces per lane and captures the first
// successful nonce of the current block in a valid/ready result register.
module nonce_result_collector #(
    parameter int NUM_CORES = 4,
    parameter int NONCEBITS = 32,
    parameter int CORE_W    = (NUM_CORES > 1) ? $clog2(NUM_CORES) : 1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [NUM_CORES-1:0] valid_i,
    input  logic [NUM_CORES-1:0] newblock_i,
    input  logic [NUM_CORES-1:0] success_i,
    output logic                 res_valid,
    input  logic                 res_ready,
    output logic [NONCEBITS-1:0] res_nonce,
    output logic [CORE_W-1:0]    res_core,
    output logic                 res_multi,
    output logic                 exhausted,
    output logic                 busy
);

    // state  | meaning
    // SEARCH | waiting for the first success of the current block
    // HOLD   | result captured, waiting for host accept
    // DONE   | block finished (accepted or exhausted), successes ignored
    typedef enum logic [1:0] {SEARCH, HOLD, DONE} state_t;

    state_t               state;
    logic [NONCEBITS-1:0] cnt        [NUM_CORES];
    logic [NONCEBITS-1:0] lane_nonce [NUM_CORES];
    logic [NUM_CORES-1:0] hit;
    logic [CORE_W-1:0]    win_core;
    logic [NONCEBITS-1:0] win_nonce;
    logic                 win_multi;
    logic                 boundary;
    logic                 lane0_last;

    always_comb begin
        for (int i = 0; i < NUM_CORES; i++) begin
            lane_nonce[i] = newblock_i[i] ? NONCEBITS'(i)
                          : cnt[i] * NONCEBITS'(NUM_CORES) + NONCEBITS'(i);
        end
    end

    assign hit        = valid_i & success_i;
    assign boundary   = valid_i[0] & newblock_i[0];
    assign lane0_last = valid_i[0] & ~newblock_i[0] & (&cnt[0]);
    assign win_multi  = $countones(hit) > 1;

    // Scan downwards so the lowest set lane wins.
    always_comb begin
        win_core  = '0;
        win_nonce = '0;
        for (int i = NUM_CORES - 1; i >= 0; i--) begin
            if (hit[i]) begin
                win_core  = CORE_W'(i);
                win_nonce = lane_nonce[i];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state     <= SEARCH;
            res_valid <= 1'b0;
            res_nonce <= '0;
            res_core  <= '0;
            res_multi <= 1'b0;
            exhausted <= 1'b0;
            busy      <= 1'b1;
            for (int i = 0; i < NUM_CORES; i++) cnt[i] <= '0;
        end else begin
            for (int i = 0; i < NUM_CORES; i++) begin
                if (valid_i[i]) cnt[i] <= newblock_i[i] ? NONCEBITS'(1) : cnt[i] + NONCEBITS'(1);
            end
            // A block boundary restarts the search and is evaluated like SEARCH.
            if (boundary || state == SEARCH) begin
                res_multi <= 1'b0;
                exhausted <= 1'b0;
                if (hit != '0) begin
                    state     <= HOLD;
                    res_valid <= 1'b1;
                    res_nonce <= win_nonce;
                    res_core  <= win_core;
                    res_multi <= win_multi;
                    busy      <= 1'b0;
                end else if (lane0_last) begin
                    state     <= DONE;
                    res_valid <= 1'b0;
                    exhausted <= 1'b1;
                    busy      <= 1'b0;
                end else begin
                    state     <= SEARCH;
                    res_valid <= 1'b0;
                    busy      <= 1'b1;
                end
            end else if (state == HOLD && res_ready) begin
                state     <= DONE;
                res_valid <= 1'b0;
                res_multi <= 1'b0;
                busy      <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_nonce_result_collector.sv
// Randomised and directed bench for nonce_result_collector against a behavioural model,
// with a 4-lane/32-bit instance and a 1-lane/4-bit instance sharing one clock.
module tb_nonce_result_collector;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    always #5 clk = ~clk;

    logic [3:0]  a_valid, a_newblock, a_success;
    logic        a_ready;
    logic        a_res_valid, a_res_multi, a_exhausted, a_busy;
    logic [31:0] a_res_nonce;
    logic [1:0]  a_res_core;

    logic [0:0]  b_valid, b_newblock, b_success;
    logic        b_ready;
    logic        b_res_valid, b_res_multi, b_exhausted, b_busy;
    logic [3:0]  b_res_nonce;
    logic [0:0]  b_res_core;

    nonce_result_collector #(.NUM_CORES(4), .NONCEBITS(32)) dut_a (
        .clk(clk), .rst(rst), .valid_i(a_valid), .newblock_i(a_newblock),
        .success_i(a_success), .res_valid(a_res_valid), .res_ready(a_ready),
        .res_nonce(a_res_nonce), .res_core(a_res_core), .res_multi(a_res_multi),
        .exhausted(a_exhausted), .busy(a_busy));

    nonce_result_collector #(.NUM_CORES(1), .NONCEBITS(4)) dut_b (
        .clk(clk), .rst(rst), .valid_i(b_valid), .newblock_i(b_newblock),
        .success_i(b_success), .res_valid(b_res_valid), .res_ready(b_ready),
        .res_nonce(b_res_nonce), .res_core(b_res_core), .res_multi(b_res_multi),
        .exhausted(b_exhausted), .busy(b_busy));

    int vectors    = 0;
    int miscompares = 0;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Model: a result is "held" until accepted; a block is "closed" once accepted or exhausted.
    longint ma_cnt [4];
    bit     ma_held, ma_closed, ma_multi, ma_exh;
    longint ma_nonce;
    int     ma_core;
    longint mb_cnt;
    bit     mb_held, mb_closed, mb_exh;
    longint mb_nonce;

    task automatic model_reset();
        for (int i = 0; i < 4; i++) ma_cnt[i] = 0;
        ma_held = 0; ma_closed = 0; ma_multi = 0; ma_exh = 0; ma_nonce = 0; ma_core = 0;
        mb_cnt = 0; mb_held = 0; mb_closed = 0; mb_exh = 0; mb_nonce = 0;
    endtask

    task automatic step_a();
        longint n [4];
        int hits;
        for (int i = 0; i < 4; i++)
            n[i] = a_newblock[i] ? i : (ma_cnt[i] * 4 + i) % 64'h1_0000_0000;
        if (a_valid[0] && a_newblock[0]) begin
            ma_held = 0; ma_closed = 0; ma_multi = 0; ma_exh = 0;
        end
        if (!ma_held && !ma_closed) begin
            hits = 0;
            for (int i = 3; i >= 0; i--) begin
                if (a_valid[i] && a_success[i]) begin
                    hits++; ma_core = i; ma_nonce = n[i];
                end
            end
            if (hits > 0) begin
                ma_held = 1; ma_multi = (hits > 1);
            end else if (a_valid[0] && !a_newblock[0] && ma_cnt[0] == 64'hFFFF_FFFF) begin
                ma_exh = 1; ma_closed = 1;
            end
        end else if (ma_held && a_ready) begin
            ma_held = 0; ma_multi = 0; ma_closed = 1;
        end
        for (int i = 0; i < 4; i++)
            if (a_valid[i]) ma_cnt[i] = a_newblock[i] ? 1 : (ma_cnt[i] + 1) % 64'h1_0000_0000;
    endtask

    task automatic step_b();
        longint n;
        n = b_newblock[0] ? 0 : mb_cnt;
        if (b_valid[0] && b_newblock[0]) begin
            mb_held = 0; mb_closed = 0; mb_exh = 0;
        end
        if (!mb_held && !mb_closed) begin
            if (b_valid[0] && b_success[0]) begin
                mb_held = 1; mb_nonce = n;
            end else if (b_valid[0] && !b_newblock[0] && mb_cnt == 15) begin
                mb_exh = 1; mb_closed = 1;
            end
        end else if (mb_held && b_ready) begin
            mb_held = 0; mb_closed = 1;
        end
        if (b_valid[0]) mb_cnt = b_newblock[0] ? 1 : (mb_cnt + 1) % 16;
    endtask

    task automatic tick(input logic [3:0] v, input logic [3:0] nb, input logic [3:0] s, input logic r);
        @(negedge clk);
        a_valid = v; a_newblock = nb; a_success = s; a_ready = r;
        if (!rst) model_reset();
        else begin
            step_a();
            step_b();
        end
        @(posedge clk);
        #1;
        chk("a_res_valid", a_res_valid, ma_held);
        chk("a_busy", a_busy, !ma_held && !ma_closed);
        chk("a_exhausted", a_exhausted, ma_exh);
        chk("a_res_multi", a_res_multi, ma_multi);
        if (ma_held) begin
            chk("a_res_nonce", a_res_nonce, ma_nonce);
            chk("a_res_core", a_res_core, ma_core);
        end
        chk("b_res_valid", b_res_valid, mb_held);
        chk("b_busy", b_busy, !mb_held && !mb_closed);
        chk("b_exhausted", b_exhausted, mb_exh);
        chk("b_res_multi", b_res_multi, 1'b0);
        if (mb_held) chk("b_res_nonce", b_res_nonce, mb_nonce);
    endtask

    logic [3:0] rv, rnb, rs;

    initial begin
        a_valid = '0; a_newblock = '0; a_success = '0; a_ready = 1'b0;
        b_valid = '0; b_newblock = '0; b_success = '0; b_ready = 1'b0;
        model_reset();
        rst = 1'b0;
        tick(4'h0, 4'h0, 4'h0, 1'b0);
        chk("reset_a_valid", a_res_valid, 1'b0);
        chk("reset_a_nonce", a_res_nonce, 0);
        chk("reset_a_busy", a_busy, 1'b1);
        rst = 1'b1;

        // Small instance: 16 beats with no success exhaust a 4-bit block.
        b_valid = 1'b1;
        for (int k = 0; k < 16; k++) tick(4'h0, 4'h0, 4'h0, 1'b0);
        chk("t5_exhausted", b_exhausted, 1'b1);
        chk("t5_busy", b_busy, 1'b0);
        b_newblock = 1'b1;
        tick(4'h0, 4'h0, 4'h0, 1'b0);
        chk("t5_clear", b_exhausted, 1'b0);
        b_newblock = 1'b0; b_valid = 1'b0;

        // Test 1: boundary, five beats, success on lane 2 at the sixth.
        tick(4'h1, 4'h1, 4'h0, 1'b0);
        for (int k = 0; k < 5; k++) tick(4'hF, 4'h0, 4'h0, 1'b0);
        tick(4'hF, 4'h0, 4'h4, 1'b0);
        chk("t1_nonce", a_res_nonce, 32'd22);
        chk("t1_core", a_res_core, 2'd2);

        // Test 2: new block with two simultaneous winners, then a long host stall.
        tick(4'hF, 4'h1, 4'hA, 1'b0);
        chk("t2_core", a_res_core, 2'd1);
        chk("t2_multi", a_res_multi, 1'b1);
        chk("t2_nonce", a_res_nonce, 32'd25);
        for (int k = 0; k < 10; k++) tick(4'hF, 4'h0, 4'(k), 1'b0);
        chk("t2_stable", a_res_nonce, 32'd25);
        tick(4'hF, 4'h0, 4'h0, 1'b1);
        chk("t2_accept", a_res_valid, 1'b0);

        // Test 3: DONE ignores success; boundary with lane 0 success wins nonce 0.
        tick(4'h8, 4'h0, 4'h8, 1'b0);
        chk("t3_ignored", a_res_valid, 1'b0);
        tick(4'h1, 4'h1, 4'h1, 1'b0);
        chk("t3_nonce", a_res_nonce, 32'd0);
        chk("t3_core", a_res_core, 2'd0);

        // Test 4: boundary while holding discards the result.
        tick(4'h1, 4'h1, 4'h0, 1'b0);
        chk("t4_drop", a_res_valid, 1'b0);
        chk("t4_busy", a_busy, 1'b1);

        // Test 6: reset while holding, then lane 1 restarts at nonce 1.
        tick(4'h4, 4'h0, 4'h4, 1'b0);
        rst = 1'b0;
        tick(4'h0, 4'h0, 4'h0, 1'b0);
        rst = 1'b1;
        chk("t6_valid", a_res_valid, 1'b0);
        chk("t6_busy", a_busy, 1'b1);
        tick(4'h2, 4'h0, 4'h2, 1'b0);
        chk("t6_nonce", a_res_nonce, 32'd1);

        // Random traffic on both instances.
        for (int k = 0; k < 3000; k++) begin
            for (int i = 0; i < 4; i++) begin
                rv[i]  = ($urandom_range(3) != 0);
                rnb[i] = ($urandom_range(24) == 0);
                rs[i]  = ($urandom_range(11) == 0);
            end
            b_valid    = ($urandom_range(7) != 0);
            b_newblock = ($urandom_range(39) == 0);
            b_success  = ($urandom_range(31) == 0);
            b_ready    = ($urandom_range(1) == 0);
            rst = ($urandom_range(299) != 0);
            tick(rv, rnb, rs, ($urandom_range(2) == 0));
            rst = 1'b1;
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
